motor_decode: RTL and testbench



---
 rtl/motor_pkg.sv | 23 ++
 rtl/pwm_capture.sv | 90 +++++++++
 rtl/motor_decode.sv | 71 +++++++
 tb/tb_motor_decode.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared constants and types for the motor drive path: mode codes, PWM period and command width.
package motor_pkg;

  localparam int unsigned PER_LOG2 = 10;
  localparam int unsigned CMD_W    = 11;

  typedef logic [CMD_W-1:0] cmd_t;
  typedef logic [2:0]       mode_t;

  localparam mode_t BRAKE = 3'd0;
  localparam mode_t FWD   = 3'd1;
  localparam mode_t REV   = 3'd2;
  localparam mode_t COAST = 3'd3;
  localparam mode_t FAULT = 3'd4;

  // Largest positive command; a full-window forward count saturates here.
  localparam cmd_t CMD_MAX = {1'b0, {(CMD_W-1){1'b1}}};

  function automatic cmd_t cmd_neg(input cmd_t x);
    return ~x + cmd_t'(1);
  endfunction

endpackage

// File: rtl/pwm_capture.sv
// One side of the decoder: registers the fwd/rev pin pair, accumulates high time over each
// window and classifies the finished window into a signed command and drive mode.
module pwm_capture
  import motor_pkg::*;
#(
  parameter int unsigned PerLog2 = PER_LOG2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  fwd,
  input  logic  rev,
  input  logic  wrap,
  output cmd_t  value,
  output mode_t mode
);

  localparam int unsigned CntW = PerLog2 + 1;
  localparam logic [CntW-1:0] Full = {1'b1, {PerLog2{1'b0}}};

  logic            fwd_q, rev_q;
  logic [CntW-1:0] fcnt_d, fcnt_q;
  logic [CntW-1:0] rcnt_d, rcnt_q;
  logic [CntW-1:0] bcnt_d, bcnt_q;
  cmd_t            value_d, value_q;
  mode_t           mode_d, mode_q;

  // The wrap-cycle sample starts the new window instead of being dropped.
  always_comb begin
    fcnt_d = '0;
    rcnt_d = '0;
    bcnt_d = '0;
    if (wrap) begin
      fcnt_d = CntW'(fwd_q);
      rcnt_d = CntW'(rev_q);
      bcnt_d = CntW'(fwd_q & rev_q);
    end else begin
      fcnt_d = fcnt_q + CntW'(fwd_q);
      rcnt_d = rcnt_q + CntW'(rev_q);
      bcnt_d = bcnt_q + CntW'(fwd_q & rev_q);
    end
  end

  // Classification sees the counts of the window that just closed.
  always_comb begin
    value_d = value_q;
    mode_d  = mode_q;
    if (wrap) begin
      if (bcnt_q == Full) begin
        mode_d  = BRAKE;
        value_d = '0;
      end else if (fcnt_q == '0 && rcnt_q == '0) begin
        mode_d  = COAST;
        value_d = '0;
      end else if (rcnt_q == '0) begin
        mode_d  = FWD;
        value_d = (fcnt_q == Full) ? CMD_MAX : cmd_t'(fcnt_q);
      end else if (fcnt_q == '0) begin
        mode_d  = REV;
        value_d = cmd_neg(cmd_t'(rcnt_q));
      end else begin
        mode_d  = FAULT;
        value_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_q   <= 1'b0;
      rev_q   <= 1'b0;
      fcnt_q  <= '0;
      rcnt_q  <= '0;
      bcnt_q  <= '0;
      value_q <= '0;
      mode_q  <= COAST;
    end else begin
      fwd_q   <= fwd;
      rev_q   <= rev;
      fcnt_q  <= fcnt_d;
      rcnt_q  <= rcnt_d;
      bcnt_q  <= bcnt_d;
      value_q <= value_d;
      mode_q  <= mode_d;
    end
  end

  assign value = value_q;
  assign mode  = mode_q;

endmodule

// File: rtl/motor_decode.sv
// Decodes the four H-bridge drive pins back into signed left/right commands and modes,
// one result per free-running measurement window.
module motor_decode #(
  parameter int unsigned PER_LOG2 = motor_pkg::PER_LOG2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_lft,
  input  logic             rev_lft,
  input  logic             fwd_rht,
  input  logic             rev_rht,
  output motor_pkg::cmd_t  lft,
  output motor_pkg::cmd_t  rht,
  output motor_pkg::mode_t lft_mode,
  output motor_pkg::mode_t rht_mode,
  output logic             valid
);

  logic [PER_LOG2-1:0] win_d, win_q;
  logic                primed_d, primed_q;
  logic                valid_d, valid_q;
  logic                wrap;

  // Counter value 1 marks the edge where the previous window's last sample has been summed.
  // The very first such edge after reset only arms the decoder: that window is still empty.
  always_comb begin
    win_d    = win_q + PER_LOG2'(1);
    wrap     = (win_q == PER_LOG2'(1)) && primed_q;
    primed_d = primed_q | (win_q == PER_LOG2'(1));
    valid_d  = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q    <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      win_q    <= win_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
    end
  end

  pwm_capture #(
    .PerLog2 (PER_LOG2)
  ) u_cap_lft (
    .clk   (clk),
    .rst   (rst),
    .fwd   (fwd_lft),
    .rev   (rev_lft),
    .wrap  (wrap),
    .value (lft),
    .mode  (lft_mode)
  );

  pwm_capture #(
    .PerLog2 (PER_LOG2)
  ) u_cap_rht (
    .clk   (clk),
    .rst   (rst),
    .fwd   (fwd_rht),
    .rev   (rev_rht),
    .wrap  (wrap),
    .value (rht),
    .mode  (rht_mode)
  );

  assign valid = valid_q;

endmodule

// File: tb/tb_motor_decode.sv
// Directed bench for motor_decode: periodic pin patterns with hand-computed decode results.
module tb_motor_decode;
  import motor_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  fwd_lft, rev_lft, fwd_rht, rev_rht;
  cmd_t  lft, rht;
  mode_t lft_mode, rht_mode;
  logic  valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int duty [4];
  int offs [4];

  typedef struct packed {
    int         dfl; int ofl;
    int         drl; int orl;
    int         dfr; int ofr;
    int         drr; int orr;
    logic [10:0] el; logic [2:0] elm;
    logic [10:0] er; logic [2:0] erm;
  } vec_t;

  vec_t vecs [8];

  motor_decode dut (
    .clk      (clk),
    .rst      (rst),
    .fwd_lft  (fwd_lft),
    .rev_lft  (rev_lft),
    .fwd_rht  (fwd_rht),
    .rev_rht  (rev_rht),
    .lft      (lft),
    .rht      (rht),
    .lft_mode (lft_mode),
    .rht_mode (rht_mode),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic pin_on(input int d, input int o, input int c);
    return ((c + 1024 - o) % 1024) < d;
  endfunction

  task automatic drive_pins();
    fwd_lft = pin_on(duty[0], offs[0], cyc);
    rev_lft = pin_on(duty[1], offs[1], cyc);
    fwd_rht = pin_on(duty[2], offs[2], cyc);
    rev_rht = pin_on(duty[3], offs[3], cyc);
  endtask

  // Cross one rising edge, then sample and drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drive_pins();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!valid && n < 1100);
    if (!valid) check({tag, "_valid_timeout"}, 32'(valid), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_lft"}, 32'(lft), 32'd0);
    check({tag, "_rht"}, 32'(rht), 32'd0);
    check({tag, "_lft_mode"}, 32'(lft_mode), 32'(COAST));
    check({tag, "_rht_mode"}, 32'(rht_mode), 32'(COAST));
    check({tag, "_valid"}, 32'(valid), 32'd0);
  endtask

  task automatic set_cfg(input vec_t v);
    duty[0] = v.dfl; offs[0] = v.ofl;
    duty[1] = v.drl; offs[1] = v.orl;
    duty[2] = v.dfr; offs[2] = v.ofr;
    duty[3] = v.drr; offs[3] = v.orr;
  endtask

  initial begin
    int n;
    vecs[0] = '{256, 0, 0, 0, 0, 0, 256, 300, 11'h100, FWD, 11'h700, REV};
    vecs[1] = '{1024, 0, 1024, 0, 0, 0, 0, 0, 11'h000, BRAKE, 11'h000, COAST};
    vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 11'h000, COAST, 11'h000, COAST};
    vecs[3] = '{1024, 0, 0, 0, 0, 0, 1024, 0, 11'h3FF, FWD, 11'h400, REV};
    vecs[4] = '{100, 0, 100, 500, 512, 7, 0, 0, 11'h000, FAULT, 11'h200, FWD};
    vecs[5] = '{1, 3, 0, 0, 0, 0, 1023, 10, 11'h001, FWD, 11'h401, REV};
    vecs[6] = '{512, 0, 512, 0, 1024, 0, 1023, 0, 11'h000, FAULT, 11'h000, FAULT};
    vecs[7] = '{0, 0, 1024, 0, 1023, 0, 0, 0, 11'h400, REV, 11'h3FF, FWD};

    for (int i = 0; i < 4; i++) begin
      duty[i] = 0;
      offs[i] = 0;
    end
    rst = 1'b1;
    drive_pins();
    steps(3);
    check_reset("por");

    // All pins idle: first valid lands after edge 1025 and reports coast on both sides.
    rst = 1'b0;
    wait_valid("first", n);
    check("first_valid_latency", 32'(n), 32'd1026);
    check("first_lft_mode", 32'(lft_mode), 32'(COAST));
    check("first_rht_mode", 32'(rht_mode), 32'(COAST));

    for (int v = 0; v < 8; v++) begin
      set_cfg(vecs[v]);
      wait_valid($sformatf("vec%0d_a", v), n);
      wait_valid($sformatf("vec%0d_b", v), n);
      check($sformatf("vec%0d_period", v), 32'(n), 32'd1024);
      check($sformatf("vec%0d_lft", v), 32'(lft), 32'(vecs[v].el));
      check($sformatf("vec%0d_lft_mode", v), 32'(lft_mode), 32'(vecs[v].elm));
      check($sformatf("vec%0d_rht", v), 32'(rht), 32'(vecs[v].er));
      check($sformatf("vec%0d_rht_mode", v), 32'(rht_mode), 32'(vecs[v].erm));
      step();
      check($sformatf("vec%0d_strobe_len", v), 32'(valid), 32'd0);
      steps(4);
      check($sformatf("vec%0d_hold_lft", v), 32'(lft), 32'(vecs[v].el));
      check($sformatf("vec%0d_hold_rht", v), 32'(rht), 32'(vecs[v].er));
    end

    // Reset at window cycle 500 with live outputs, then time the recovery.
    set_cfg(vecs[0]);
    wait_valid("mid_a", n);
    wait_valid("mid_b", n);
    check("mid_pre_lft", 32'(lft), 32'h100);
    steps(498);
    rst = 1'b1;
    step();
    check_reset("mid_rst");
    rst = 1'b0;
    wait_valid("mid_recover", n);
    check("mid_recover_latency", 32'(n), 32'd1026);
    check("mid_recover_lft", 32'(lft), 32'h100);
    check("mid_recover_rht", 32'(rht), 32'h700);

    // Reset on the wrap edge itself must suppress that window's strobe.
    steps(1023);
    check("wrap_pre_valid", 32'(valid), 32'd0);
    check("wrap_pre_lft", 32'(lft), 32'h100);
    rst = 1'b1;
    step();
    check_reset("wrap_rst");
    rst = 1'b0;
    step();
    check("wrap_post_valid", 32'(valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
